// File: rtl/upload_arb_pkg.sv
// Shared definitions for the upload channel arbiter.
//   arb_state_e     : arbiter FSM state encoding
//   SRC_*           : requester index assignments
//   DEFAULT_NUM_SRC : default number of requesters
package upload_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam int unsigned SRC_UART = 0;
  localparam int unsigned SRC_SPI  = 1;
  localparam int unsigned SRC_DSM  = 2;

  localparam int unsigned DEFAULT_NUM_SRC = 3;

endpackage

// File: rtl/upload_rr_pick.sv
// Combinational round-robin picker.
//   eligible : per-source eligibility vector
//   rr_ptr   : index that has highest priority this round
//   found    : at least one source is eligible
//   index    : first eligible index at or after rr_ptr, modulo NUM_SRC
module upload_rr_pick #(
  parameter int unsigned NUM_SRC = 3
) (
  input  logic [NUM_SRC-1:0]         eligible,
  input  logic [$clog2(NUM_SRC)-1:0] rr_ptr,
  output logic                       found,
  output logic [$clog2(NUM_SRC)-1:0] index
);

  localparam int unsigned IW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] rot;
  int unsigned        j;
  int unsigned        sel;

  always_comb begin
    rot   = '0;
    j     = 0;
    sel   = 0;
    found = 1'b0;
    index = '0;
    // Rotate so rr_ptr lands at bit 0.
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      j = 32'(rr_ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      rot[k] = eligible[j];
    end
    // Lowest set bit wins; scanning downward lets the last hit be the lowest.
    for (int unsigned k = NUM_SRC; k > 0; k--) begin
      if (rot[k-1]) begin
        found = 1'b1;
        sel   = k - 1;
      end
    end
    // Undo the rotation.
    j = 32'(rr_ptr) + sel;
    if (j >= NUM_SRC) j = j - NUM_SRC;
    index = IW'(j);
  end

endmodule

// File: rtl/upload_arbiter.sv
// Packet-level round-robin arbiter for the command processor upload channel.
// One source owns the channel for a whole packet; a watchdog forces release
// of a grant that sees no transfer for TIMEOUT_CYCLES cycles.
//   src_req/src_valid/src_data/src_source/src_ready : per-source upload ports
//   up_req/up_valid/up_data/up_source/up_ready      : merged upload port
//   grant_id      : current or last grantee
//   busy          : channel granted
//   timeout_pulse : one cycle high after a forced release
module upload_arbiter
  import upload_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC        = DEFAULT_NUM_SRC,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [8*NUM_SRC-1:0]       src_data,
  input  logic [8*NUM_SRC-1:0]       src_source,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       up_req,
  output logic                       up_valid,
  output logic [7:0]                 up_data,
  output logic [7:0]                 up_source,
  input  logic                       up_ready,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_pulse
);

  localparam int unsigned GW = $clog2(NUM_SRC);
  localparam int unsigned WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WW'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_e         state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]      wd_cnt_q, wd_cnt_d;
  logic [NUM_SRC-1:0] stuck_q, stuck_d;
  logic               timeout_q, timeout_d;

  logic               pick_found;
  logic [GW-1:0]      pick_idx;
  logic               xfer;
  logic               wd_expire;

  upload_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .eligible (src_req & ~stuck_q),
    .rr_ptr   (rr_ptr_q),
    .found    (pick_found),
    .index    (pick_idx)
  );

  // Zero-latency pass-through from the grantee; valid is withheld once its
  // req has dropped so nothing leaks after the packet end.
  always_comb begin
    up_req    = 1'b0;
    up_valid  = 1'b0;
    up_data   = '0;
    up_source = '0;
    src_ready = '0;
    if (state_q == ST_GRANT) begin
      up_req              = src_req[grant_q];
      up_valid            = src_valid[grant_q] & src_req[grant_q];
      up_data             = src_data[8*grant_q +: 8];
      up_source           = src_source[8*grant_q +: 8];
      src_ready[grant_q]  = up_ready;
    end
  end

  assign xfer          = up_valid & up_ready;
  assign wd_expire     = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST) && !xfer;
  assign busy          = (state_q == ST_GRANT);
  assign grant_id      = grant_q;
  assign timeout_pulse = timeout_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    wd_cnt_d  = wd_cnt_q;
    stuck_d   = stuck_q & src_req;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d  = ST_GRANT;
          grant_d  = pick_idx;
          rr_ptr_d = (32'(pick_idx) == NUM_SRC - 1) ? '0 : pick_idx + GW'(1);
          wd_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        // A req drop wins over a coincident expiry: normal release, no stuck.
        if (!src_req[grant_q]) begin
          state_d = ST_RELEASE;
        end else if (wd_expire) begin
          state_d           = ST_RELEASE;
          stuck_d[grant_q]  = 1'b1;
          timeout_d         = 1'b1;
        end else if (xfer) begin
          wd_cnt_d = '0;
        end else if (wd_cnt_q != '1) begin
          wd_cnt_d = wd_cnt_q + WW'(1);
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      wd_cnt_q  <= '0;
      stuck_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_cnt_q  <= wd_cnt_d;
      stuck_q   <= stuck_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: doc/upload_arbiter.md
# upload_arbiter

Packet-level round-robin arbiter that shares the command processor's single upload channel between the upload-capable handlers (UART, SPI, DSM). It replaces the OR/priority merge with a locked grant: one source owns the channel for a whole packet, and no two sources' bytes can interleave. A watchdog releases a grant that stalls. It sits between the handlers' upload ports and the command processor's upload inputs, in the clk domain.

## Interface
- NUM_SRC, 3, number of requesters; index 0 = UART, 1 = SPI, 2 = DSM.
- TIMEOUT_CYCLES, 65535, cycles in GRANT without a handshake before forced release; 0 disables the watchdog.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- src_req  in  NUM_SRC  per-source packet request; held high for the whole packet.
- src_valid  in  NUM_SRC  per-source byte valid.
- src_data  in  8*NUM_SRC  per-source byte; source i at [8i+7:8i].
- src_source  in  8*NUM_SRC  per-source source ID; same packing as src_data.
- src_ready  out  NUM_SRC  per-source ready; only the granted bit can be 1.
- up_req  out  1  merged request to the command processor.
- up_valid  out  1  merged valid.
- up_data  out  8  merged byte.
- up_source  out  8  merged source ID.
- up_ready  in  1  ready from the command processor.
- grant_id  out  $clog2(NUM_SRC)  current or last grantee.
- busy  out  1  high while in GRANT.
- timeout_pulse  out  1  one-cycle pulse on a forced release.

## Operation
- The FSM has three states: IDLE, GRANT and RELEASE.
- **IDLE:** a source is eligible when src_req[i]=1 and stuck[i]=0.
  - If any source is eligible, grant the first eligible index at or after rr_ptr, wrapping modulo NUM_SRC.
  - On the grant: register grant_id, set rr_ptr = grant+1 (wrapping), clear wd_cnt, go to GRANT.
- **GRANT:** the datapath is a zero-latency combinational pass-through from source g = grant_id.
  - up_req = src_req[g]; up_valid = src_valid[g]; up_data and up_source come from slice g.
  - src_ready[g] = up_ready. All other src_ready bits are 0.
  - A byte transfers when up_valid & up_ready.
  - Valid from non-granted sources is ignored; those sources are stalled by ready=0.
- **GRANT → RELEASE:** taken when src_req[g] falls. It is also taken when the watchdog expires; in that case set stuck[g] and pulse timeout_pulse.
- **RELEASE:** all up_* outputs are 0. Go to IDLE next cycle. This guarantees the command processor sees up_req low for at least 1 cycle between packets.
- **Watchdog:** wd_cnt counts GRANT cycles and clears on every transfer. Expiry is wd_cnt == TIMEOUT_CYCLES-1 with no transfer in that cycle. The watchdog is inactive when TIMEOUT_CYCLES=0.
- **stuck[i]:** cleared in any cycle where src_req[i]=0. A source that timed out cannot regain the grant until it drops req.
- **Width rules:**
  - wd_cnt is $clog2(TIMEOUT_CYCLES+1) bits and saturates (never wraps).
  - rr_ptr wraps from NUM_SRC-1 to 0.
- **Reset values:**
  - State: state=IDLE, rr_ptr=0, grant_id=0, wd_cnt=0, stuck=0.
  - Outputs: all up_* = 0, src_ready = 0, busy = 0, timeout_pulse = 0.

## Timing
- **Request to grant:** src_req rising in IDLE in cycle N gives busy=1 and up_req=1 in cycle N+1.
  - A byte already valid in N+1 transfers in N+1 if up_ready=1.
- **Packet end:** src_req[g] falling in cycle M gives RELEASE in M+1 and IDLE in M+2. The earliest next grant is M+3.
- **Simultaneous events:**
  - Several requests arriving in the same IDLE cycle: the round-robin pointer decides.
  - src_req[g] dropping in the same cycle as watchdog expiry: treated as a normal release; stuck is not set and there is no timeout_pulse.
- **Last byte:** a byte presented with up_valid while src_req[g] is still 1 transfers normally. After src_req[g]=0, up_req=0 and valid is not forwarded.
- **Reset mid-packet:** all outputs go to 0 asynchronously. After release, the arbiter restarts from IDLE with rr_ptr=0.

## Structure
- **Shared package `upload_arb_pkg`:**
  - State encoding (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2).
  - Source index constants SRC_UART=0, SRC_SPI=1, SRC_DSM=2.
  - Default NUM_SRC.
- **Sub-module `upload_rr_pick`:** purely combinational. Inputs are the eligible vector and rr_ptr; outputs are found and index. It rotates the vector, runs a priority encode, and un-rotates the result. Parameterised by NUM_SRC.
- **Top module contents:** the FSM, the watchdog counter, the stuck register and the output muxes.

## Test plan
- **Single source:** UART raises req with 4 bytes 0x11..0x14 and up_ready=1.
  - busy=1 one cycle later; 4 transfers with up_source equal to UART's ID.
  - up_req low for 1 cycle after req drops.
- **Simultaneous requests:** all three req rise in the same cycle from reset, each sending a 2-byte packet.
  - Grants occur in order 0, 1, 2; no byte interleaving; a ≥1-cycle up_req gap between packets.
- **Fairness:** sources 0 and 2 request continuously, 1-byte packets.
  - Grants alternate 0, 2, 0, 2; source 0 is never granted twice in a row.
- **Backpressure:** up_ready held 0 for 10 cycles mid-packet, with TIMEOUT_CYCLES=16.
  - src_ready[g]=0 throughout; no byte lost; packet completes after up_ready returns; no timeout_pulse.
- **Watchdog:** TIMEOUT_CYCLES=8; SPI holds req with valid=0.
  - timeout_pulse after 8 GRANT cycles; DSM is granted next.
  - SPI is not re-granted until it drops and re-raises req.
- **Reset mid-packet:** rst_n asserted mid-packet on byte 2 of 4.
  - All outputs 0 immediately.
  - After release, a new request from source 1 is granted with grant_id=1.
